psram_cmd_driver: RTL and testbench

Serial/quad bus engine for the Tang Nano 1k on-board PSRAM. It sits directly downstream of the PSRAM initialisation/access controller, which issues one transaction at a time: RSTEN, RST, enter-QPI, reads and writes. The engine turns each request into the chip-select, clock and SPI/QPI data waveform on `mem_ce`/`mem_clk`/`mem_sio`. It returns read data with a one-cycle valid pulse.

---
 rtl/psram_cmd_driver.sv | 174 +++++++++++++++++
 tb/tb_psram_cmd_driver.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_cmd_driver.sv
// rtl/psram_cmd_driver.sv - SPI/QPI bus engine for the on-board PSRAM (CE, SCLK, SIO waveforms)
module psram_cmd_driver #(
    parameter int WAIT_CYCLES = 6,
    parameter int CE_HIGH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic        req_qpi,
    input  logic        req_has_addr,
    input  logic [23:0] req_addr,
    input  logic        req_wr,
    input  logic [7:0]  req_wdata,
    input  logic        req_rd,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        mem_ce,
    output logic        mem_clk,
    inout  wire  [3:0]  mem_sio
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_WDATA, S_RDATA, S_CEH
    } state_t;

    localparam logic [7:0] WAIT_LEN = 8'(WAIT_CYCLES);
    localparam logic [7:0] CEH_LEN  = 8'(CE_HIGH);

    state_t      state;
    state_t      nxt_phase;
    state_t      after_addr;
    logic [7:0]  cnt;
    logic        qpi_q;
    logic        has_addr_q;
    logic        wr_q;
    logic        rd_q;
    logic [39:0] tx_shift;
    logic [39:0] tx_next;
    logic [3:0]  sio_next;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_next;
    logic [3:0]  sio_o;
    logic [3:0]  sio_oe;

    // Number of SCLK periods spent in a phase for the given lane mode.
    function automatic logic [7:0] phase_len(input state_t s, input logic q);
        case (s)
            S_CMD, S_WDATA, S_RDATA: phase_len = q ? 8'd2 : 8'd8;
            S_ADDR:                  phase_len = q ? 8'd6 : 8'd24;
            S_WAIT:                  phase_len = WAIT_LEN;
            default:                 phase_len = 8'd0;
        endcase
    endfunction

    // Pad drivers: each lane is released independently so SPI leaves sio[3:1] floating.
    for (genvar i = 0; i < 4; i++) begin : g_sio
        assign mem_sio[i] = sio_oe[i] ? sio_o[i] : 1'bz;
    end

    // Next phase after the current one ends, plus the shifted transmit/receive words.
    always_comb begin
        after_addr = S_CEH;
        if (wr_q) begin
            after_addr = S_WDATA;
        end else if (rd_q) begin
            after_addr = (qpi_q && (WAIT_CYCLES > 0)) ? S_WAIT : S_RDATA;
        end
        case (state)
            S_CMD:   nxt_phase = has_addr_q ? S_ADDR : after_addr;
            S_ADDR:  nxt_phase = after_addr;
            S_WAIT:  nxt_phase = S_RDATA;
            default: nxt_phase = S_CEH;
        endcase
        tx_next  = qpi_q ? {tx_shift[35:0], 4'h0} : {tx_shift[38:0], 1'b0};
        sio_next = qpi_q ? tx_next[39:36] : {3'b000, tx_next[39]};
        rx_next  = qpi_q ? {rx_shift[3:0], mem_sio} : {rx_shift[6:0], mem_sio[1]};
    end

    // Transaction sequencer: odd edges raise SCLK, even edges lower it, shift data and step phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            qpi_q      <= 1'b0;
            has_addr_q <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            tx_shift   <= 40'd0;
            rx_shift   <= 8'd0;
            sio_o      <= 4'h0;
            sio_oe     <= 4'h0;
            req_ready  <= 1'b1;
            mem_ce     <= 1'b1;
            mem_clk    <= 1'b0;
            rd_data    <= 8'd0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        qpi_q      <= req_qpi;
                        has_addr_q <= req_has_addr;
                        wr_q       <= req_wr;
                        rd_q       <= req_rd;
                        tx_shift   <= req_has_addr ? {req_cmd, req_addr, req_wdata}
                                                   : {req_cmd, req_wdata, 24'h0};
                        rx_shift   <= 8'd0;
                        sio_o      <= req_qpi ? req_cmd[7:4] : {3'b000, req_cmd[7]};
                        sio_oe     <= req_qpi ? 4'hF : 4'h1;
                        cnt        <= phase_len(S_CMD, req_qpi);
                        state      <= S_CMD;
                        mem_ce     <= 1'b0;
                        mem_clk    <= 1'b0;
                        req_ready  <= 1'b0;
                    end
                end
                S_CEH: begin
                    if (cnt == 8'd1) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    if (!mem_clk) begin
                        mem_clk <= 1'b1;
                    end else begin
                        mem_clk <= 1'b0;
                        if (state == S_RDATA) begin
                            rx_shift <= rx_next;
                        end
                        if (cnt != 8'd1) begin
                            cnt <= cnt - 8'd1;
                            if (state != S_WAIT && state != S_RDATA) begin
                                tx_shift <= tx_next;
                                sio_o    <= sio_next;
                            end
                        end else begin
                            state <= nxt_phase;
                            cnt   <= phase_len(nxt_phase, qpi_q);
                            case (nxt_phase)
                                S_ADDR, S_WDATA: begin
                                    tx_shift <= tx_next;
                                    sio_o    <= sio_next;
                                end
                                S_WAIT, S_RDATA: begin
                                    sio_oe <= 4'h0;
                                end
                                default: begin
                                    mem_ce <= 1'b1;
                                    sio_oe <= 4'h0;
                                    cnt    <= CEH_LEN;
                                    if (state == S_RDATA) begin
                                        rd_data  <= rx_next;
                                        rd_valid <= 1'b1;
                                    end
                                    if (CE_HIGH == 0) begin
                                        state     <= S_IDLE;
                                        req_ready <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_cmd_driver.sv
// tb/tb_psram_cmd_driver.sv - randomized self-checking bench for psram_cmd_driver
`timescale 1ns/1ps
module tb_psram_cmd_driver;
    localparam int WAIT_CYCLES = 6;
    localparam int CE_HIGH     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_cmd = 8'h0;
    logic        req_qpi = 1'b0;
    logic        req_has_addr = 1'b0;
    logic [23:0] req_addr = 24'h0;
    logic        req_wr = 1'b0;
    logic [7:0]  req_wdata = 8'h0;
    logic        req_rd = 1'b0;
    logic [7:0]  rbyte_in = 8'h0;
    wire         req_ready;
    wire  [7:0]  rd_data;
    wire         rd_valid;
    wire         mem_ce;
    wire         mem_clk;
    wire  [3:0]  mem_sio;
    logic [3:0]  tb_en = 4'h0;
    logic [3:0]  tb_v = 4'h0;

    int n_tests = 0;
    int n_fail  = 0;

    psram_cmd_driver #(.WAIT_CYCLES(WAIT_CYCLES), .CE_HIGH(CE_HIGH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_qpi(req_qpi), .req_has_addr(req_has_addr),
        .req_addr(req_addr), .req_wr(req_wr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rd_data(rd_data), .rd_valid(rd_valid), .mem_ce(mem_ce), .mem_clk(mem_clk),
        .mem_sio(mem_sio)
    );

    // PSRAM side: weak pull-ups make released lanes read 1; the bench drives read data.
    for (genvar g = 0; g < 4; g++) begin : g_bus
        pullup (mem_sio[g]);
        assign mem_sio[g] = tb_en[g] ? tb_v[g] : 1'bz;
    end

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [39:0] a, input logic [39:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, a, e);
        end
    endtask

    // Reference model: per-transaction list of SCLK periods, timed by cycles since accept.
    bit          m_busy = 1'b0;
    int          m_t = 0;
    int          m_n = 0;
    int          m_acc = 0;
    bit          m_qpi = 1'b0;
    bit          m_is_read = 1'b0;
    logic [7:0]  m_rd_byte = 8'h0;
    logic [7:0]  m_rd_data = 8'h0;
    logic [3:0]  e_val [64];
    logic [3:0]  e_drv [64];
    int          e_rd  [64];

    function automatic bit model_ready();
        return !m_busy || (m_t >= 2 * m_n + CE_HIGH);
    endfunction

    task automatic build_txn();
        logic [7:0] bytes [$];
        logic [7:0] b;
        int n;
        bytes.push_back(req_cmd);
        if (req_has_addr) begin
            bytes.push_back(req_addr[23:16]);
            bytes.push_back(req_addr[15:8]);
            bytes.push_back(req_addr[7:0]);
        end
        if (req_wr) bytes.push_back(req_wdata);
        n = 0;
        foreach (bytes[i]) begin
            b = bytes[i];
            if (req_qpi) begin
                e_val[n] = b[7:4]; e_drv[n] = 4'hF; e_rd[n] = -1; n++;
                e_val[n] = b[3:0]; e_drv[n] = 4'hF; e_rd[n] = -1; n++;
            end else begin
                for (int j = 7; j >= 0; j--) begin
                    e_val[n] = {3'b000, b[j]}; e_drv[n] = 4'h1; e_rd[n] = -1; n++;
                end
            end
        end
        m_is_read = req_rd && !req_wr;
        if (m_is_read) begin
            if (req_qpi) begin
                for (int j = 0; j < WAIT_CYCLES; j++) begin
                    e_val[n] = 4'h0; e_drv[n] = 4'h0; e_rd[n] = -1; n++;
                end
            end
            for (int j = 0; j < (req_qpi ? 2 : 8); j++) begin
                e_val[n] = 4'h0; e_drv[n] = 4'h0; e_rd[n] = j; n++;
            end
        end
        m_n       = n;
        m_qpi     = req_qpi;
        m_rd_byte = rbyte_in;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    = 1'b0;
            m_t       = 0;
            m_rd_data = 8'h0;
        end else if (req_valid && model_ready()) begin
            build_txn();
            m_busy = 1'b1;
            m_t    = 0;
            m_acc++;
        end else if (m_busy) begin
            m_t++;
            if (m_is_read && m_t == 2 * m_n) m_rd_data = m_rd_byte;
        end
    end

    // PSRAM read responder: presents each read bit/nibble for its whole SCLK period.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_en = 4'h0;
        end else begin
            #1;
            if (m_busy && m_t < 2 * m_n && e_rd[m_t / 2] >= 0) begin
                if (m_qpi) begin
                    tb_en = 4'hF;
                    tb_v  = (e_rd[m_t / 2] == 0) ? m_rd_byte[7:4] : m_rd_byte[3:0];
                end else begin
                    tb_en = 4'b0010;
                    tb_v  = {2'b00, m_rd_byte[7 - e_rd[m_t / 2]], 1'b0};
                end
            end else begin
                tb_en = 4'h0;
            end
        end
    end

    // Compare every output against the model on every falling edge.
    always @(negedge clk) begin : cmp
        bit         act;
        int         k;
        logic [3:0] e_l;
        act = m_busy && (m_t < 2 * m_n);
        k   = act ? m_t / 2 : 0;
        e_l = 4'hF;
        for (int i = 0; i < 4; i++) if (act && e_drv[k][i]) e_l[i] = e_val[k][i];
        chk("mem_ce",    40'(mem_ce),    40'(!act));
        chk("mem_clk",   40'(mem_clk),   40'(act && (m_t % 2 == 1)));
        chk("req_ready", 40'(req_ready), 40'(model_ready()));
        chk("rd_valid",  40'(rd_valid),  40'(m_busy && m_is_read && (m_t == 2 * m_n)));
        chk("rd_data",   40'(rd_data),   40'(m_rd_data));
        chk("mem_sio",   40'(mem_sio & ~tb_en), 40'(e_l & ~tb_en));
    end

    // Waveform observer feeding the hand-computed scenario checks.
    logic [3:0] cap [$];
    int  rdv_cnt = 0, ce_low_run = 0, hi_run = 0, last_ce_low = 0, last_gap = 0;
    int  rr_cnt = 0, last_rr = 0;
    bit  rr_on = 1'b0, prev_ce = 1'b1;
    always @(negedge clk) begin
        if (rst_n && !mem_ce && mem_clk) cap.push_back(mem_sio);
        if (rd_valid) rdv_cnt++;
        if (!mem_ce) begin
            if (prev_ce) begin last_gap = hi_run; ce_low_run = 0; end
            ce_low_run++;
        end else begin
            if (!prev_ce) begin last_ce_low = ce_low_run; hi_run = 0; rr_on = 1'b1; rr_cnt = 0; end
            hi_run++;
        end
        if (rr_on) begin
            if (req_ready) begin last_rr = rr_cnt; rr_on = 1'b0; end
            else rr_cnt++;
        end
        prev_ce = mem_ce;
    end

    function automatic logic [39:0] pack_nib(input int first, input int cnt_n);
        logic [39:0] v = 40'h0;
        for (int i = first; i < first + cnt_n && i < cap.size(); i++) v = {v[35:0], cap[i]};
        return v;
    endfunction

    function automatic logic [7:0] pack_spi();
        logic [7:0] v = 8'h0;
        foreach (cap[i]) v = {v[6:0], cap[i][0]};
        return v;
    endfunction

    task automatic wait_accept(input int c0);
        int to = 0;
        while (m_acc == c0 && to < 300) begin @(posedge clk); #2; to++; end
        chk("accept_timeout", 40'(m_acc != c0), 40'd1);
        cap.delete();
        rdv_cnt = 0;
    endtask

    task automatic send(input logic [7:0] c, input logic q, input logic ha, input logic [23:0] a,
                        input logic w, input logic [7:0] wd, input logic r, input logic [7:0] rb,
                        input bit hold);
        int c0 = m_acc;
        req_cmd = c; req_qpi = q; req_has_addr = ha; req_addr = a;
        req_wr = w; req_wdata = wd; req_rd = r; rbyte_in = rb;
        req_valid = 1'b1;
        wait_accept(c0);
        if (!hold) begin
            req_valid = 1'b0;
            req_cmd = 8'($urandom); req_qpi = 1'($urandom); req_has_addr = 1'($urandom);
            req_addr = 24'($urandom); req_wr = 1'($urandom); req_wdata = 8'($urandom);
            req_rd = 1'($urandom);
        end
    endtask

    task automatic wait_idle();
        int to = 0;
        do begin @(posedge clk); #2; to++; end while (req_ready !== 1'b1 && to < 300);
        chk("idle_timeout", 40'(req_ready), 40'd1);
        @(posedge clk); #2;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

        send(8'h66, 1'b0, 1'b0, 24'h0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0);
        wait_idle();
        chk("rsten_bits",   40'(pack_spi()),  40'h66);
        chk("rsten_edges",  40'(cap.size()),  40'd8);
        chk("rsten_ce_low", 40'(last_ce_low), 40'd16);
        chk("rsten_ready",  40'(last_rr),     40'd4);

        send(8'h38, 1'b1, 1'b1, 24'h012345, 1'b1, 8'hA5, 1'b0, 8'h0, 1'b0);
        wait_idle();
        chk("qwr_nibbles", pack_nib(0, 10),   40'h38012345A5);
        chk("qwr_edges",   40'(cap.size()),  40'd10);
        chk("qwr_ce_low",  40'(last_ce_low), 40'd20);
        chk("qwr_no_rdv",  40'(rdv_cnt),     40'd0);

        send(8'hEB, 1'b1, 1'b1, 24'h000010, 1'b0, 8'h0, 1'b1, 8'h5C, 1'b0);
        wait_idle();
        chk("qrd_hdr",     pack_nib(0, 8),   40'hEB000010);
        chk("qrd_wait_z",  pack_nib(8, 6),   40'hFFFFFF);
        chk("qrd_ce_low",  40'(last_ce_low), 40'd32);
        chk("qrd_data",    40'(rd_data),     40'h5C);
        chk("qrd_rdv",     40'(rdv_cnt),     40'd1);

        send(8'h03, 1'b0, 1'b1, 24'h000000, 1'b0, 8'h0, 1'b1, 8'h3C, 1'b0);
        wait_idle();
        chk("srd_ce_low",  40'(last_ce_low), 40'd80);
        chk("srd_data",    40'(rd_data),     40'h3C);
        chk("srd_edges",   40'(cap.size()),  40'd40);

        send(8'h66, 1'b0, 1'b0, 24'h0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
        req_cmd = 8'h99;
        wait_accept(m_acc);
        req_valid = 1'b0;
        wait_idle();
        chk("b2b_gap",     40'(last_gap),    40'd5);
        chk("b2b_bits",    40'(pack_spi()),  40'h99);
        chk("b2b_ce_low",  40'(last_ce_low), 40'd16);

        send(8'h38, 1'b1, 1'b1, 24'h012345, 1'b1, 8'hA5, 1'b0, 8'h0, 1'b0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ce",      40'(mem_ce),    40'd1);
        chk("rst_clk",     40'(mem_clk),   40'd0);
        chk("rst_ready",   40'(req_ready), 40'd1);
        chk("rst_sio",     40'(mem_sio),   40'hF);
        chk("rst_rd_data", 40'(rd_data),   40'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        send(8'h66, 1'b0, 1'b0, 24'h0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0);
        wait_idle();
        chk("post_rst_bits",   40'(pack_spi()),  40'h66);
        chk("post_rst_ce_low", 40'(last_ce_low), 40'd16);
        chk("post_rst_ready",  40'(last_rr),     40'd4);

        for (int it = 0; it < 40; it++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), ($urandom_range(0, 2) == 0),
                 8'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
        req_valid = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
